// File: rtl/param_memory_pkg.sv
// Shared types and default geometry for the parameterised boot/run memory.
package param_memory_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int IO_BASE_DEF = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    BOOT  = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/param_memory_if.sv
// CPU strobe, HPS boot and status signals of param_memory; DataBus stays a plain inout.
interface param_memory_if
  import param_memory_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int IO_BASE = IO_BASE_DEF
) ();

  localparam int IO_DEPTH = (1 << ADDR_W) - IO_BASE;

  logic [ADDR_W-1:0]   MemAddr;
  logic                MemWrite;
  logic                MemRead;
  logic                BusDrive;
  logic                BootLoad;
  logic                BootValid;
  logic                BootReady;
  logic [ADDR_W-1:0]   BootAddr;
  logic [DATA_W-1:0]   BootWData;
  logic [DATA_W-1:0]   BootRData;
  logic                Busy;
  logic [IO_DEPTH-1:0] IoLsbs;

  modport master (
    output MemAddr, MemWrite, MemRead, BusDrive,
    output BootLoad, BootValid, BootAddr, BootWData,
    input  BootReady, BootRData, Busy, IoLsbs
  );

  modport slave (
    input  MemAddr, MemWrite, MemRead, BusDrive,
    input  BootLoad, BootValid, BootAddr, BootWData,
    output BootReady, BootRData, Busy, IoLsbs
  );

endinterface

// File: rtl/mem_array.sv
// Storage array: one write port, a held CPU output register and a free-running readback register.
module mem_array
  import param_memory_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int IO_BASE = IO_BASE_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [ADDR_W-1:0]                 waddr,
  input  logic [DATA_W-1:0]                 wdata,
  input  logic                              rd_en,
  input  logic [ADDR_W-1:0]                 raddr,
  output logic [DATA_W-1:0]                 rdata,
  input  logic [ADDR_W-1:0]                 rb_addr,
  output logic [DATA_W-1:0]                 rb_data,
  output logic [(1 << ADDR_W)-IO_BASE-1:0]  io_lsbs
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int IO_DEPTH = DEPTH - IO_BASE;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;

  // NOTE: the array has no reset so program words survive Reset; the I/O region is zeroed by CLEAR instead.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d   = rd_en ? mem_q[raddr] : rdata_q;
    rb_data_d = mem_q[rb_addr];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      rb_data_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      rb_data_q <= rb_data_d;
    end
  end

  assign rdata   = rdata_q;
  assign rb_data = rb_data_q;

  for (genvar k = 0; k < IO_DEPTH; k++) begin : g_io
    assign io_lsbs[k] = mem_q[IO_BASE + k][0];
  end

endmodule

// File: rtl/param_memory.sv
// Boot-loadable memory: CLEAR zeroes the I/O region, BOOT takes HPS beats, RUN serves the CPU bus.
module param_memory
  import param_memory_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int IO_BASE = IO_BASE_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  inout  wire  [DATA_W-1:0] DataBus,
  param_memory_if.slave     bus
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;
  logic              boot_ready_q, boot_ready_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [DATA_W-1:0] out_reg;
  logic [DATA_W-1:0] bus_in;

  assign bus_in = DataBus;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_A) state_d = bus.BootLoad ? BOOT : RUN;
      end
      BOOT: begin
        if (!bus.BootLoad) begin
          state_d   = CLEAR;
          clr_cnt_d = IO_BASE_A;
        end
      end
      RUN: begin
        if (bus.BootLoad) state_d = BOOT;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = IO_BASE_A;
      end
    endcase
    busy_d       = (state_d == CLEAR);
    boot_ready_d = (state_d == BOOT);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= IO_BASE_A;
      busy_q       <= 1'b1;
      boot_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      busy_q       <= busy_d;
      boot_ready_q <= boot_ready_d;
    end
  end

  // Single write port shared by the clear sweep, boot beats and CPU writes; nothing lands in a reset cycle.
  always_comb begin
    we    = 1'b0;
    waddr = clr_cnt_q;
    wdata = '0;
    rd_en = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        CLEAR: we = 1'b1;
        BOOT: begin
          we    = bus.BootValid;
          waddr = bus.BootAddr;
          wdata = bus.BootWData;
        end
        RUN: begin
          we    = bus.MemWrite;
          waddr = bus.MemAddr;
          wdata = bus_in;
          rd_en = bus.MemRead && !bus.MemWrite;
        end
        default: we = 1'b0;
      endcase
    end
  end

  mem_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .IO_BASE (IO_BASE)
  ) u_mem_array (
    .clk     (clk),
    .rst     (Reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_en   (rd_en),
    .raddr   (bus.MemAddr),
    .rdata   (out_reg),
    .rb_addr (bus.BootAddr),
    .rb_data (bus.BootRData),
    .io_lsbs (bus.IoLsbs)
  );

  assign bus.Busy      = busy_q;
  assign bus.BootReady = boot_ready_q;

  assign DataBus = (bus.BusDrive && state_q == RUN) ? out_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench: stimulus pushes expected outputs per cycle, a negedge monitor pops and compares.
module tb_param_memory;

  localparam int DEPTH = 16;
  localparam int IO_B  = 8;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  param_memory_if #(.DATA_W(8), .ADDR_W(4), .IO_BASE(8)) b1 ();
  param_memory_if #(.DATA_W(16), .ADDR_W(5), .IO_BASE(24)) b2 ();

  wire  [7:0]  data_bus;
  logic        tb_drv;
  logic [7:0]  tb_dat;
  assign data_bus = tb_drv ? tb_dat : 8'hzz;

  wire  [15:0] data_bus2;
  assign data_bus2 = 16'hA5C3;

  param_memory #(.DATA_W(8), .ADDR_W(4), .IO_BASE(8)) dut (
    .clk (clk), .Reset (Reset), .DataBus (data_bus), .bus (b1.slave)
  );

  param_memory #(.DATA_W(16), .ADDR_W(5), .IO_BASE(24)) dut2 (
    .clk (clk), .Reset (Reset), .DataBus (data_bus2), .bus (b2.slave)
  );

  typedef struct {
    bit       rst, mw, mr, bd, bl, bv;
    bit [3:0] ma, ba;
    bit [7:0] bus_d, bw;
  } in_t;

  typedef struct {
    bit         busy, brdy;
    logic [7:0] rb;
    bit         rb_kn;
    logic [7:0] io, io_mask;
    bit         bus_chk;
    logic [7:0] bus;
    bit         busy2;
    logic [7:0] io2_mask;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents with a known flag, plus a coarse operating mode.
  localparam int M_CLR = 0, M_BOOT = 1, M_RUN = 2;
  logic [7:0] m [DEPTH];
  bit         kn [DEPTH];
  int         mode = M_CLR;
  int         ci   = IO_B;
  logic [7:0] out_v;
  bit         out_kn;
  logic [7:0] rb_v;
  bit         rb_kn;
  int         c2 = 0;
  logic [7:0] kn2 = 8'h00;

  function automatic in_t idle();
    in_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic model(input in_t s);
    if (s.rst) begin
      mode = M_CLR; ci = IO_B;
      out_v = 8'h00; out_kn = 1'b1;
      rb_v = 8'h00; rb_kn = 1'b1;
      c2 = 0;
    end else begin
      rb_v  = m[s.ba];
      rb_kn = kn[s.ba];
      case (mode)
        M_CLR: begin
          m[ci] = 8'h00; kn[ci] = 1'b1;
          if (ci == DEPTH - 1) mode = s.bl ? M_BOOT : M_RUN;
          else ci++;
        end
        M_BOOT: begin
          if (s.bv) begin m[s.ba] = s.bw; kn[s.ba] = 1'b1; end
          if (!s.bl) begin mode = M_CLR; ci = IO_B; end
        end
        default: begin
          if (s.mw) begin m[s.ma] = s.bus_d; kn[s.ma] = 1'b1; end
          else if (s.mr) begin out_v = m[s.ma]; out_kn = kn[s.ma]; end
          if (s.bl) mode = M_BOOT;
        end
      endcase
      if (c2 < 8) begin kn2[c2] = 1'b1; c2++; end
    end
  endtask

  function automatic exp_t expect_now(input in_t s);
    exp_t e;
    e.busy  = (mode == M_CLR);
    e.brdy  = (mode == M_BOOT);
    e.rb    = rb_v;
    e.rb_kn = rb_kn;
    for (int k = 0; k < DEPTH - IO_B; k++) begin
      e.io[k]      = m[IO_B + k][0];
      e.io_mask[k] = kn[IO_B + k];
    end
    e.bus_chk = 1'b0;
    e.bus     = 8'h00;
    if (s.bd && mode == M_RUN && out_kn) begin e.bus_chk = 1'b1; e.bus = out_v; end
    else if (!s.bd) begin e.bus_chk = 1'b1; e.bus = s.bus_d; end
    e.busy2    = (c2 < 8);
    e.io2_mask = kn2;
    return e;
  endfunction

  task automatic step(input in_t s);
    Reset        = s.rst;
    b1.MemWrite  = s.mw;  b1.MemRead  = s.mr;  b1.MemAddr  = s.ma;
    b1.BusDrive  = s.bd;  b1.BootLoad = s.bl;  b1.BootValid = s.bv;
    b1.BootAddr  = s.ba;  b1.BootWData = s.bw;
    tb_drv       = !s.bd;
    tb_dat       = s.bus_d;
    @(posedge clk);
    model(s);
    sb.push_back(expect_now(s));
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("busy", 32'(b1.Busy), 32'(e.busy));
        check("boot_ready", 32'(b1.BootReady), 32'(e.brdy));
        if (e.rb_kn) check("boot_rdata", 32'(b1.BootRData), 32'(e.rb));
        if (e.io_mask != 8'h00) check("io_lsbs", 32'(b1.IoLsbs & e.io_mask), 32'(e.io & e.io_mask));
        if (e.bus_chk) check("data_bus", 32'(data_bus), 32'(e.bus));
        check("busy_w16", 32'(b2.Busy), 32'(e.busy2));
        if (e.io2_mask != 8'h00) check("io_lsbs_w16", 32'(b2.IoLsbs & e.io2_mask), 32'h0);
        check("data_bus_w16", 32'(data_bus2), 32'hA5C3);
      end
    end
  end

  initial begin : stim
    in_t s;
    bit  bl_state;
    for (int i = 0; i < DEPTH; i++) kn[i] = 1'b0;
    b2.MemWrite = 1'b0; b2.MemRead = 1'b0; b2.MemAddr = '0; b2.BusDrive = 1'b0;
    b2.BootLoad = 1'b0; b2.BootValid = 1'b0; b2.BootAddr = '0; b2.BootWData = '0;

    // Reset, then 8 clear cycles and RUN
    s = idle(); s.rst = 1'b1; step(s); step(s);
    s = idle(); repeat (10) step(s);

    // Boot two beats, leave BOOT, observe clear of word 9
    s = idle(); s.bl = 1'b1; step(s);
    s.bv = 1'b1; s.ba = 4'd0; s.bw = 8'h1A; step(s);
    s.ba = 4'd9; s.bw = 8'hFF; step(s);
    s.bv = 1'b0; s.ba = 4'd0; s.bl = 1'b0; step(s);
    s = idle(); s.ba = 4'd9; repeat (9) step(s);

    // CPU write then read-with-drive of word 12
    s = idle(); s.mw = 1'b1; s.ma = 4'd12; s.bus_d = 8'h03; step(s);
    s = idle(); s.mr = 1'b1; s.ma = 4'd12; s.bd = 1'b1; step(s);
    s.mr = 1'b0; step(s);

    // Simultaneous read and write: write wins, register holds
    s = idle(); s.mw = 1'b1; s.mr = 1'b1; s.ma = 4'd2; s.bus_d = 8'h55; step(s);
    s = idle(); s.bd = 1'b1; step(s);
    s.mr = 1'b1; s.ma = 4'd2; step(s);
    s.mr = 1'b0; step(s);

    // Reset after three boot beats; beat in reset cycle dropped
    s = idle(); s.bl = 1'b1; step(s);
    s.bv = 1'b1;
    for (int a = 1; a <= 3; a++) begin s.ba = 4'(a); s.bw = 8'(8'h30 + a); step(s); end
    s.rst = 1'b1; s.ba = 4'd4; s.bw = 8'h77; step(s);
    s = idle(); s.bl = 1'b1; repeat (9) step(s);
    for (int a = 1; a <= 4; a++) begin s.ba = 4'(a); step(s); end
    s.bl = 1'b0; step(s);
    s = idle(); repeat (9) step(s);

    // Randomized traffic
    bl_state = 1'b0;
    for (int i = 0; i < 600; i++) begin
      s = idle();
      if ($urandom_range(0, 15) == 0) bl_state = !bl_state;
      s.bl    = bl_state;
      s.bv    = 1'($urandom_range(0, 1));
      s.ba    = 4'($urandom);
      s.bw    = 8'($urandom);
      s.mw    = ($urandom_range(0, 3) == 0);
      s.mr    = ($urandom_range(0, 2) == 0);
      s.ma    = 4'($urandom);
      s.bd    = s.mw ? 1'b0 : 1'($urandom_range(0, 1));
      s.bus_d = 8'($urandom);
      s.rst   = ($urandom_range(0, 79) == 0);
      step(s);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The parameter DATA_W SHALL default to 8 and set the word width and DataBus width.
REQ-002 The parameter ADDR_W SHALL default to 4 and set the depth (DEPTH = 2**ADDR_W words).
REQ-003 The parameter IO_BASE SHALL default to 8 and set the first address of the I/O region, which runs from IO_BASE to DEPTH-1 (IO_DEPTH = DEPTH-IO_BASE words).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 DataBus  inout  DATA_W  shared CPU bus.
REQ-007 MemAddr  input  ADDR_W  CPU address.
REQ-008 MemWrite  input  1  CPU write strobe: capture DataBus into word MemAddr.
REQ-009 MemRead  input  1  CPU read strobe: load word MemAddr into the output register.
REQ-010 BusDrive  input  1  enables the output register onto DataBus.
REQ-011 BootLoad  input  1  HPS boot mode request, level.
REQ-012 BootValid  input  1  HPS write beat valid.
REQ-013 BootReady  output  1  block accepts a boot beat this cycle.
REQ-014 BootAddr  input  ADDR_W  HPS address, used for both write and readback.
REQ-015 BootWData  input  DATA_W  HPS write data.
REQ-016 BootRData  output  DATA_W  registered readback of word BootAddr.
REQ-017 Busy  output  1  high while the block is in CLEAR.
REQ-018 IoLsbs  output  IO_DEPTH  bit k = bit 0 of word IO_BASE+k.

Function
REQ-019 The state machine SHALL have the states CLEAR, BOOT and RUN.
REQ-020 CLEAR SHALL zero one I/O word per cycle, from IO_BASE upward, using a counter; after writing DEPTH-1 it SHALL go to BOOT if BootLoad=1, else to RUN.
REQ-021 CLEAR SHALL ignore CPU strobes and boot beats; BootReady SHALL be 0 in CLEAR.
REQ-022 In RUN, BootLoad=1 SHALL move the block to BOOT on the next cycle.
REQ-023 In BOOT, BootReady SHALL be 1, and BootValid=1 SHALL write BootWData to BootAddr in that cycle.
REQ-024 In BOOT, the CPU strobes SHALL be ignored.
REQ-025 In BOOT, BootLoad=0 SHALL move the block to CLEAR, so the I/O region is zeroed after every boot.
REQ-026 In RUN, MemWrite=1 SHALL write DataBus to MemAddr.
REQ-027 In RUN, MemRead=1 with MemWrite=0 SHALL load the output register 1 cycle later.
REQ-028 When MemRead and MemWrite are both high, the write SHALL win and the output register SHALL hold.
REQ-029 DataBus SHALL be driven only when BusDrive=1 and the state is RUN; otherwise it SHALL be all-Z at the full DATA_W width.
REQ-030 BootRData SHALL be registered every cycle in all states from word BootAddr, with the full address.
REQ-031 When a boot write and a readback hit the same address, BootRData SHALL show the old value, with the new value on the next cycle.
REQ-032 IoLsbs SHALL be combinational from array state and SHALL reflect writes the cycle after they occur.
REQ-033 Address arithmetic SHALL wrap modulo DEPTH; no out-of-range address exists.

Reset
REQ-034 Reset=1 SHALL enter CLEAR with the counter at IO_BASE.
REQ-035 On reset, the output register, BootRData and BootReady SHALL be 0 and Busy SHALL be 1.
REQ-036 Words below IO_BASE SHALL NOT be reset, so program contents survive.
REQ-037 Reset asserted mid-CLEAR or mid-BOOT SHALL restart CLEAR from IO_BASE.
REQ-038 A boot beat in the reset cycle SHALL be dropped.

Structure
REQ-039 A shared package SHALL hold the state enum (CLEAR/BOOT/RUN) and the default DATA_W/ADDR_W/IO_BASE constants.
REQ-040 The storage array with its single write port and the two registered read ports SHALL be the sub-module mem_array; the FSM, write-port muxing and tristate SHALL stay in param_memory.

Verification
REQ-041 Reset with defaults -> Busy=1 for 8 cycles, IoLsbs=8'h00, then RUN with Busy=0.
REQ-042 BootLoad=1, beats (0,8'h1A) and (9,8'hFF), then BootLoad=0 -> BootRData@0=8'h1A, 8 CLEAR cycles, word 9 reads 0, IoLsbs=0.
REQ-043 RUN, MemWrite addr 12 data 8'h03, then MemRead 12 with BusDrive=1 -> DataBus=8'h03 one cycle after the read, IoLsbs[4]=1.
REQ-044 MemRead and MemWrite on addr 2 with data 8'h55 in the same cycle -> output register unchanged, a later read returns 8'h55.
REQ-045 Reset mid-BOOT after 3 beats -> beats kept below IO_BASE, CLEAR restarts at 8, BootReady=0 until BOOT is re-entered.
REQ-046 DATA_W=16, ADDR_W=5, IO_BASE=24 -> 8-cycle CLEAR, IoLsbs 8 bits wide, DataBus all-Z (16 bits) while BusDrive=0.
